// File: rtl/cop_exc_ctrl.sv
// cop_exc_ctrl: coprocessor-0 exception/interrupt sequencer (CAUSE/EPC/STATUS, flush, PC redirect).
// Define COP_TIMER_IRQ_EN to add the COUNT/COMPARE timer interrupt on CAUSE[15].
module cop_exc_ctrl #(
  parameter logic [31:0] EXCEPTION_ENTRY = 32'h80000000,
  parameter int unsigned NUM_IRQ         = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               instr_valid,
  input  logic [31:0]        instr_pc,
  input  logic [31:0]        next_pc,
  input  logic               exc_sys,
  input  logic               exc_brk,
  input  logic               exc_ri,
  input  logic               eret,
  input  logic               ie_wr,
  input  logic               ie_wdata,
  input  logic               cmp_wr,
  input  logic [31:0]        cmp_wdata,
  output logic               flush,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  input  logic               redirect_ack,
  output logic [31:0]        cause_out,
  output logic [31:0]        epc_out,
  output logic [31:0]        status_out,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_REDIRECT} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [NUM_IRQ-1:0] r_irqPend;
  logic [4:0]         r_excCode;
  logic [31:0]        r_epc;
  logic [31:0]        r_redirectPc;
  logic               r_ie;
  logic               r_exl;
  logic               w_timerPend;
  logic               w_sampling;
  logic               w_syncExc;
  logic               w_eretGo;
  logic               w_intTake;
  logic               w_fire;
  logic               w_ieWrite;
  logic [4:0]         w_code;
  logic [31:0]        w_cause;

`ifdef COP_TIMER_IRQ_EN
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_timerPend;

  // A COMPARE write in the same cycle as a match clears the pending bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_compare   <= '1;
      r_timerPend <= 1'b0;
    end else begin
      r_count <= r_count + 32'd1;
      if (cmp_wr) begin
        r_compare   <= cmp_wdata;
        r_timerPend <= 1'b0;
      end else if (r_count == r_compare) begin
        r_timerPend <= 1'b1;
      end
    end
  end

  assign w_timerPend = r_timerPend;
`else
  logic w_unused;
  assign w_unused    = ^{cmp_wr, cmp_wdata};
  assign w_timerPend = 1'b0;
`endif

  // A no-op eret (EXL=0) does not block a lower-priority interrupt or IE write.
  always_comb begin
    w_sampling = (r_state == S_IDLE) && instr_valid;
    w_syncExc  = w_sampling && (exc_ri || exc_sys || exc_brk);
    w_eretGo   = w_sampling && !w_syncExc && eret && r_exl;
    w_intTake  = w_sampling && !w_syncExc && !w_eretGo &&
                 ((|r_irqPend) || w_timerPend) && r_ie && !r_exl;
    w_fire     = w_syncExc || w_eretGo || w_intTake;
    w_ieWrite  = w_sampling && !w_fire && ie_wr;
    w_code     = 5'd0;
    if (w_syncExc) begin
      if (exc_ri)       w_code = 5'd10;
      else if (exc_sys) w_code = 5'd8;
      else              w_code = 5'd9;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irqPend    <= '0;
      r_excCode    <= '0;
      r_epc        <= '0;
      r_redirectPc <= '0;
      r_ie         <= 1'b1;
      r_exl        <= 1'b0;
    end else begin
      r_irqPend <= irq_in;
      if (w_syncExc || w_intTake) begin
        r_excCode    <= w_code;
        r_exl        <= 1'b1;
        r_epc        <= w_syncExc ? next_pc : instr_pc;
        r_redirectPc <= EXCEPTION_ENTRY;
      end else if (w_eretGo) begin
        r_exl        <= 1'b0;
        r_redirectPc <= r_epc;
      end else if (w_ieWrite) begin
        r_ie <= ie_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:     if (w_fire) w_nextState = S_FLUSH;
      S_FLUSH:    w_nextState = S_REDIRECT;
      S_REDIRECT: if (redirect_ack) w_nextState = S_IDLE;
      default:    w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    flush          = (r_state == S_FLUSH);
    redirect_valid = (r_state == S_REDIRECT);
    busy           = (r_state != S_IDLE);
  end

  // Timer pending shares CAUSE[15] with the top hardware line.
  always_comb begin
    w_cause                = '0;
    w_cause[6:2]           = r_excCode;
    w_cause[10 +: NUM_IRQ] = r_irqPend;
    w_cause[15]            = w_cause[15] | w_timerPend;
  end

  assign cause_out   = w_cause;
  assign epc_out     = r_epc;
  assign status_out  = {30'd0, r_exl, r_ie};
  assign redirect_pc = r_redirectPc;

endmodule

// File: tb/tb_cop_exc_ctrl.sv
// Testbench for cop_exc_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_cop_exc_ctrl;

  localparam logic [31:0] ENTRY = 32'h80000000;

  logic        clk;
  logic        rst;
  logic [5:0]  irq_in;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic [31:0] next_pc;
  logic        exc_sys;
  logic        exc_brk;
  logic        exc_ri;
  logic        eret;
  logic        ie_wr;
  logic        ie_wdata;
  logic        cmp_wr;
  logic [31:0] cmp_wdata;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ack;
  logic [31:0] cause_out;
  logic [31:0] epc_out;
  logic [31:0] status_out;
  logic        busy;

  int nChecks = 0;
  int nFails  = 0;

  // Behavioural model: architectural registers plus "flush due" / "waiting for ack" facts.
  bit          mValid = 0;
  bit          mFlush;
  bit          mWaiting;
  logic [31:0] mPc;
  logic [4:0]  mCode;
  logic [31:0] mEpc;
  bit          mIE;
  bit          mEXL;
  logic [5:0]  mPend;
  logic [31:0] mCount;
  logic [31:0] mCompare;
  bit          mTimer;

  cop_exc_ctrl #(.EXCEPTION_ENTRY(ENTRY), .NUM_IRQ(6)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .instr_valid(instr_valid),
    .instr_pc(instr_pc), .next_pc(next_pc), .exc_sys(exc_sys), .exc_brk(exc_brk),
    .exc_ri(exc_ri), .eret(eret), .ie_wr(ie_wr), .ie_wdata(ie_wdata),
    .cmp_wr(cmp_wr), .cmp_wdata(cmp_wdata), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ack(redirect_ack), .cause_out(cause_out), .epc_out(epc_out),
    .status_out(status_out), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic modelStep;
    bit busyNow, sampling, syncExc, eretGo, intGo, match;
    if (rst) begin
      mValid = 1; mFlush = 0; mWaiting = 0; mPc = 0; mCode = 0; mEpc = 0;
      mIE = 1; mEXL = 0; mPend = 0; mCount = 0; mCompare = 32'hFFFFFFFF; mTimer = 0;
      return;
    end
    if (!mValid) return;
    busyNow  = mFlush || mWaiting;
    sampling = !busyNow && instr_valid;
    syncExc  = sampling && (exc_ri || exc_sys || exc_brk);
    eretGo   = sampling && !syncExc && eret && mEXL;
    intGo    = sampling && !syncExc && !eretGo && mIE && !mEXL && ((mPend != 0) || mTimer);
    if (mFlush) begin
      mFlush = 0; mWaiting = 1;
    end else if (mWaiting && redirect_ack) begin
      mWaiting = 0;
    end
    if (syncExc) begin
      mCode = exc_ri ? 5'd10 : (exc_sys ? 5'd8 : 5'd9);
      mEpc = next_pc; mEXL = 1; mPc = ENTRY; mFlush = 1;
    end else if (intGo) begin
      mCode = 5'd0; mEpc = instr_pc; mEXL = 1; mPc = ENTRY; mFlush = 1;
    end else if (eretGo) begin
      mEXL = 0; mPc = mEpc; mFlush = 1;
    end else if (sampling && ie_wr) begin
      mIE = ie_wdata;
    end
`ifdef COP_TIMER_IRQ_EN
    match = (mCount == mCompare);
    if (cmp_wr) begin
      mCompare = cmp_wdata; mTimer = 0;
    end else if (match) begin
      mTimer = 1;
    end
    mCount = mCount + 32'd1;
`else
    match = 0;
`endif
    mPend = irq_in;
  endtask

  task automatic checkOutput;
    logic [31:0] expCause;
    if (!mValid) return;
    expCause = {16'd0, mPend[5] | mTimer, mPend[4:0], 3'd0, mCode, 2'd0};
    checkEq("flush", 32'(flush), 32'(mFlush));
    checkEq("redirect_valid", 32'(redirect_valid), 32'(mWaiting));
    checkEq("busy", 32'(busy), 32'(mFlush || mWaiting));
    checkEq("redirect_pc", redirect_pc, mPc);
    checkEq("cause_out", cause_out, expCause);
    checkEq("epc_out", epc_out, mEpc);
    checkEq("status_out", status_out, {30'd0, mEXL, mIE});
  endtask

  task automatic stepCycle;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic setIdle;
    rst = 0; irq_in = 0; instr_valid = 0; instr_pc = 0; next_pc = 0;
    exc_sys = 0; exc_brk = 0; exc_ri = 0; eret = 0; ie_wr = 0; ie_wdata = 0;
    cmp_wr = 0; cmp_wdata = 0; redirect_ack = 0;
  endtask

  task automatic applyStimulus;
    rst          = ($urandom_range(0, 199) == 0);
    instr_valid  = ($urandom_range(0, 1) == 1);
    exc_ri       = ($urandom_range(0, 15) == 0);
    exc_sys      = ($urandom_range(0, 15) == 0);
    exc_brk      = ($urandom_range(0, 15) == 0);
    eret         = ($urandom_range(0, 5) == 0);
    ie_wr        = ($urandom_range(0, 5) == 0);
    ie_wdata     = ($urandom_range(0, 1) == 1);
    irq_in       = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
    instr_pc     = $urandom & 32'hFFFFFFFC;
    next_pc      = instr_pc + 32'd4;
    redirect_ack = ($urandom_range(0, 2) == 0);
    cmp_wr       = ($urandom_range(0, 31) == 0);
    cmp_wdata    = mCount + 32'($urandom_range(1, 40));
  endtask

  initial begin
    setIdle();
    rst = 1;
    stepCycle();
    stepCycle();
    rst = 0;
    checkEq("reset_status", status_out, 32'h1);
    checkEq("reset_cause", cause_out, 32'h0);

    // syscall: flush next cycle, redirect the cycle after, held until ack
    instr_valid = 1; exc_sys = 1; instr_pc = 32'h00400020; next_pc = 32'h00400024;
    stepCycle();
    setIdle();
    checkEq("sys_flush", 32'(flush), 32'd1);
    stepCycle();
    checkEq("sys_flush_one_cycle", 32'(flush), 32'd0);
    checkEq("sys_redirect_valid", 32'(redirect_valid), 32'd1);
    checkEq("sys_redirect_pc", redirect_pc, 32'h80000000);
    checkEq("sys_epc", epc_out, 32'h00400024);
    checkEq("sys_code", 32'(cause_out[6:2]), 32'd8);
    checkEq("sys_status", status_out, 32'h3);
    stepCycle();
    stepCycle();
    checkEq("sys_hold_valid", 32'(redirect_valid), 32'd1);
    redirect_ack = 1;
    stepCycle();
    redirect_ack = 0;
    checkEq("sys_ack_valid", 32'(redirect_valid), 32'd0);
    checkEq("sys_ack_busy", 32'(busy), 32'd0);

    // ri beats brk; then eret returns to EPC and clears EXL
    instr_valid = 1; exc_ri = 1; exc_brk = 1; next_pc = 32'h00400040;
    stepCycle();
    setIdle();
    stepCycle();
    checkEq("ri_code", 32'(cause_out[6:2]), 32'd10);
    redirect_ack = 1;
    stepCycle();
    setIdle();
    instr_valid = 1; eret = 1;
    stepCycle();
    setIdle();
    checkEq("eret_flush", 32'(flush), 32'd1);
    stepCycle();
    checkEq("eret_redirect_pc", redirect_pc, 32'h00400040);
    checkEq("eret_code_kept", 32'(cause_out[6:2]), 32'd10);
    redirect_ack = 1;
    stepCycle();
    setIdle();
    checkEq("eret_status", status_out, 32'h1);

    // interrupt on line 2
    irq_in = 6'b000100;
    stepCycle();
    instr_valid = 1; instr_pc = 32'h00400100; next_pc = 32'h00400104;
    stepCycle();
    instr_valid = 0;
    checkEq("irq_pending_bit", 32'(cause_out[12]), 32'd1);
    checkEq("irq_flush", 32'(flush), 32'd1);
    stepCycle();
    checkEq("irq_code", 32'(cause_out[6:2]), 32'd0);
    checkEq("irq_epc", epc_out, 32'h00400100);
    redirect_ack = 1;
    stepCycle();
    setIdle();
    instr_valid = 1; eret = 1;
    stepCycle();
    setIdle();
    stepCycle();
    redirect_ack = 1;
    stepCycle();
    setIdle();

    // IE cleared first: interrupt stays pending but is not taken
    instr_valid = 1; ie_wr = 1; ie_wdata = 0;
    stepCycle();
    setIdle();
    checkEq("ie_clear_status", status_out, 32'h0);
    irq_in = 6'b000100;
    stepCycle();
    instr_valid = 1; instr_pc = 32'h00400200;
    stepCycle();
    checkEq("masked_pending", 32'(cause_out[12]), 32'd1);
    checkEq("masked_no_flush", 32'(flush), 32'd0);
    checkEq("masked_not_busy", 32'(busy), 32'd0);
    setIdle();
    stepCycle();
    stepCycle();
    instr_valid = 1; ie_wr = 1; ie_wdata = 1;
    stepCycle();
    setIdle();

    // eret with EXL=0 is a no-op
    instr_valid = 1; eret = 1;
    stepCycle();
    setIdle();
    checkEq("eret_noop_flush", 32'(flush), 32'd0);
    checkEq("eret_noop_busy", 32'(busy), 32'd0);
    stepCycle();
    checkEq("eret_noop_redirect", 32'(redirect_valid), 32'd0);

    // reset held two cycles while in REDIRECT
    instr_valid = 1; exc_brk = 1; next_pc = 32'h00400300;
    stepCycle();
    setIdle();
    stepCycle();
    checkEq("pre_reset_redirect", 32'(redirect_valid), 32'd1);
    rst = 1;
    stepCycle();
    stepCycle();
    rst = 0;
    checkEq("rst_flush", 32'(flush), 32'd0);
    checkEq("rst_redirect", 32'(redirect_valid), 32'd0);
    checkEq("rst_status", status_out, 32'h1);
    checkEq("rst_cause", cause_out, 32'h0);
    checkEq("rst_epc", epc_out, 32'h0);
    checkEq("rst_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      stepCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
